// File: rtl/jacobi_result_reader.sv
// Jacobi result reader: streams N eigenvalues (packed-triangle diagonal)
// then the N*N eigenvector matrix out of Jacobi memory over valid/ready.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start / busy / done  readout request, in-progress flag, end pulse
//   rd_en/rd_addr/rd_data  memory read port (1-cycle read latency)
//   m_tdata/m_tvalid/m_tready/m_tuser/m_tlast  output stream
//     m_tuser=1 on eigenvalue words, m_tlast on the final word
module jacobi_result_reader #(
  parameter int N        = 8,
  parameter int DW       = 20,
  parameter int AW       = 7,
  parameter int V_OFFSET = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tuser,
  output logic          m_tlast
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);
  localparam int SW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EIG,
    S_VEC,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } ent_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] step_q, step_d;

  logic          fl_q;
  logic          fl_user_q;
  logic          fl_last_q;

  ent_t          fifo_q [2];
  logic          wptr_q;
  logic          rptr_q;
  logic [1:0]    occ_q;

  logic          done_q;

  ent_t          head;
  logic          push;
  logic          pop;
  logic [2:0]    load;
  logic          room;
  logic          eig_last;
  logic          vec_last;
  logic          fin;

  assign head     = fifo_q[rptr_q];
  assign m_tvalid = (occ_q != 2'd0);
  assign m_tdata  = m_tvalid ? head.data : '0;
  assign m_tuser  = m_tvalid & head.user;
  assign m_tlast  = m_tvalid & head.last;

  assign push = fl_q;
  assign pop  = m_tvalid & m_tready;

  // Words held plus words in flight, less this cycle's pop, must
  // stay below 2 for a new read to be safe.
  assign load = {1'b0, occ_q} + {2'b00, fl_q} - {2'b00, pop};
  assign room = (load < 3'd2);

  assign eig_last = (cnt_q == CW'(N - 1));
  assign vec_last = (cnt_q == CW'(NN - 1));
  assign fin      = pop & head.last;

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign rd_addr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_EIG;
      end
      S_EIG: begin
        rd_en = room;
        if (room && eig_last) state_d = S_VEC;
      end
      S_VEC: begin
        rd_en = room;
        if (room && vec_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Diagonal of the packed triangle: addr += step, step counts
  // down from N, so no multiply is needed.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    step_d = step_q;
    if (state_q == S_IDLE && start) begin
      cnt_d  = '0;
      addr_d = '0;
      step_d = SW'(N);
    end else if (rd_en) begin
      if (state_q == S_EIG) begin
        if (eig_last) begin
          cnt_d  = '0;
          addr_d = AW'(V_OFFSET);
        end else begin
          cnt_d  = cnt_q + CW'(1);
          addr_d = addr_q + AW'(step_q);
          step_d = step_q - SW'(1);
        end
      end else begin
        if (vec_last) begin
          cnt_d  = '0;
          addr_d = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          addr_d = addr_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      step_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      step_q <= step_d;
    end
  end

  // Tags ride alongside the outstanding read until its data lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_q      <= 1'b0;
      fl_user_q <= 1'b0;
      fl_last_q <= 1'b0;
    end else begin
      fl_q      <= rd_en;
      fl_user_q <= rd_en & (state_q == S_EIG);
      fl_last_q <= rd_en & (state_q == S_VEC) & vec_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= '{data: rd_data,
                            user: fl_user_q,
                            last: fl_last_q};
        wptr_q <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_DRAIN) & fin;
    end
  end

endmodule
